// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: state encodings, coin values
// and the 4x4 goods price table.
package vending_pkg;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_SELECT   = 6'b000010,
    S_CONFIRM  = 6'b000100,
    S_PAY      = 6'b001000,
    S_DISPENSE = 6'b010000,
    S_CHANGE   = 6'b100000
  } state_e;

  localparam logic [7:0] COIN_1_VAL  = 8'd1;
  localparam logic [7:0] COIN_5_VAL  = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;
  localparam logic [7:0] MONEY_MAX   = 8'd99;

  // Row-major by (high, low), both 1..4; every entry is at most 30.
  localparam logic [4:0] PRICE_TBL [16] = '{
    5'd5,  5'd8,  5'd10, 5'd12,
    5'd10, 5'd12, 5'd15, 5'd18,
    5'd18, 5'd20, 5'd22, 5'd25,
    5'd25, 5'd27, 5'd28, 5'd30
  };

  // Digits 1..4 map to 0..3 by subtracting one in two bits (4 -> 3).
  function automatic logic [6:0] price_of(input logic [1:0] hi, input logic [1:0] lo,
                                          input logic [1:0] num);
    logic [3:0] idx;
    idx = {hi - 2'd1, lo - 2'd1};
    return {2'b00, PRICE_TBL[idx]} * {5'b00000, num};
  endfunction

endpackage

// File: rtl/coin_acc.sv
// Coin accumulator: adds every coin pulse of a cycle while enabled and
// saturates the running total at MONEY_MAX.
module coin_acc
  import vending_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en,
  input  logic       clr,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [7:0] money,
  output logic [7:0] money_nxt
);

  logic [7:0] money_q, money_d, sum, raw;

  always_comb begin
    sum = (coin_1 ? COIN_1_VAL : 8'd0) + (coin_5 ? COIN_5_VAL : 8'd0)
        + (coin_10 ? COIN_10_VAL : 8'd0);
    raw = money_q + sum;
    money_nxt = money_q;
    if (en) money_nxt = (raw > MONEY_MAX) ? MONEY_MAX : raw;
    money_d = clr ? 8'd0 : money_nxt;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) money_q <= 8'd0;
    else         money_q <= money_d;
  end

  assign money = money_q;

endmodule

// File: rtl/vending_ctrl.sv
// Vending machine controller: goods selection, payment, dispense and change.
// Define VENDING_TIMEOUT_EN to add an inactivity timeout in SELECT/CONFIRM/PAY.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned DISP_CYCLES    = 200_000_000,
  parameter int unsigned HOLD_CYCLES    = 300_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd3_000_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_start,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       btn_num,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [5:0] state,
  output logic [6:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [2:0] in_goods_high,
  output logic [2:0] in_goods_low,
  output logic [1:0] in_goods_num,
  output logic       dispense
);

  state_e      state_q, state_d;
  logic [6:0]  need_q, need_d;
  logic [7:0]  chg_q, chg_d;
  logic [2:0]  hi_q, hi_d, lo_q, lo_d;
  logic [1:0]  num_q, num_d;
  logic        disp_q, disp_d;
  logic [31:0] cnt_q, cnt_d;
  logic        acc_en, acc_clr, to_idle, goods_ok, tmo_hit;
  logic [7:0]  acc_money, acc_nxt;

  // CLK_FREQ is informational only; the dwell limits are given in cycles.
  logic unused_cfg;
  assign unused_cfg = ^{CLK_FREQ, TIMEOUT_CYCLES};

`ifdef VENDING_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_run, any_pulse;

  always_comb begin
    any_pulse = btn_start | btn_confirm | btn_cancel | btn_num | key_valid
              | coin_1 | coin_5 | coin_10;
    tmo_run = (state_q == S_SELECT) | (state_q == S_CONFIRM) | (state_q == S_PAY);
    tmo_hit = tmo_run & ~any_pulse & (tmo_q == TIMEOUT_CYCLES - 32'd1);
    tmo_d   = (tmo_run & ~any_pulse & ~tmo_hit) ? tmo_q + 32'd1 : 32'd0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tmo_q <= 32'd0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  coin_acc u_coin_acc (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (acc_en),
    .clr      (acc_clr),
    .coin_1   (coin_1),
    .coin_5   (coin_5),
    .coin_10  (coin_10),
    .money    (acc_money),
    .money_nxt(acc_nxt)
  );

  assign goods_ok = (hi_q >= 3'd1) && (hi_q <= 3'd4) && (lo_q >= 3'd1) && (lo_q <= 3'd4);

  always_comb begin
    state_d = state_q;
    need_d  = need_q;
    chg_d   = chg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    num_d   = num_q;
    disp_d  = 1'b0;
    cnt_d   = cnt_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      S_IDLE: if (btn_start) state_d = S_SELECT;
      S_SELECT: begin
        if (btn_cancel) to_idle = 1'b1;
        else begin
          if (key_valid) begin
            hi_d = lo_q;
            lo_d = key_code;
          end
          if (btn_num) num_d = (num_q == 2'd3) ? 2'd1 : num_q + 2'd1;
          if (btn_confirm && goods_ok) state_d = S_CONFIRM;
          else if (tmo_hit)            to_idle = 1'b1;
        end
      end
      S_CONFIRM: begin
        need_d = price_of(hi_q[1:0], lo_q[1:0], num_q);
        if (btn_cancel)       to_idle = 1'b1;
        else if (btn_confirm) state_d = S_PAY;
        else if (tmo_hit)     to_idle = 1'b1;
      end
      S_PAY: begin
        acc_en = 1'b1;
        // Coins landing in the exit cycle still count toward change/refund.
        if (acc_money >= {1'b0, need_q}) begin
          state_d = S_DISPENSE;
          chg_d   = acc_nxt - {1'b0, need_q};
          disp_d  = 1'b1;
          cnt_d   = 32'd0;
        end else if (btn_cancel || tmo_hit) begin
          state_d = S_CHANGE;
          chg_d   = acc_nxt;
          cnt_d   = 32'd0;
        end
      end
      S_DISPENSE: begin
        if (cnt_q >= DISP_CYCLES - 32'd1) begin
          state_d = S_CHANGE;
          cnt_d   = 32'd0;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_CHANGE: begin
        if (cnt_q >= HOLD_CYCLES - 32'd1) begin
          to_idle = 1'b1;
          cnt_d   = 32'd0;
        end else cnt_d = cnt_q + 32'd1;
      end
      default: to_idle = 1'b1;
    endcase
    // Every return to IDLE starts the next customer from the reset picture.
    if (to_idle) begin
      state_d = S_IDLE;
      need_d  = 7'd0;
      chg_d   = 8'd0;
      hi_d    = 3'd0;
      lo_d    = 3'd0;
      num_d   = 2'd1;
      acc_clr = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      need_q  <= 7'd0;
      chg_q   <= 8'd0;
      hi_q    <= 3'd0;
      lo_q    <= 3'd0;
      num_q   <= 2'd1;
      disp_q  <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      chg_q   <= chg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      num_q   <= num_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state         = state_q;
  assign need_money    = need_q;
  assign input_money   = acc_money;
  assign change_money  = chg_q;
  assign in_goods_high = hi_q;
  assign in_goods_low  = lo_q;
  assign in_goods_num  = num_q;
  assign dispense      = disp_q;

endmodule
